// File: rtl/ie_if.sv
// rtl/ie_if.sv - field-set input and encoded-word output bundle for the instruction encoder
interface ie_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [6:0]                    in_opcode;
    logic [4:0]                    in_rd;
    logic [4:0]                    in_rs1;
    logic [4:0]                    in_rs2;
    logic [2:0]                    in_funct3;
    logic [6:0]                    in_funct7;
    logic [31:0]                   in_imm;
    logic                          in_clear_err;
    logic                          out_valid;
    logic                          out_ready;
    logic [31:0]                   out_instruction;
    logic [ADDR_WIDTH-1:0]         out_addr;
    logic                          out_illegal;
    logic [$clog2(FIFO_DEPTH):0]   out_count;

    // Producer/consumer side: drives fields and out_ready, observes the queue.
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, in_clear_err, out_ready,
        input  in_ready, out_valid, out_instruction, out_addr, out_illegal, out_count
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, in_clear_err, out_ready,
        output in_ready, out_valid, out_instruction, out_addr, out_illegal, out_count
    );
endinterface

// File: rtl/ie.sv
// rtl/ie.sv - RISC-V instruction encoder with address-tagged output FIFO
module ie #(
    parameter int INSTRUCTON_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int ADDR_WIDTH       = 10
) (
    input logic  clk,
    input logic  rst_n,
    ie_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    fmt_e                        fmt;
    logic                        legal;
    logic [INSTRUCTON_WIDTH-1:0] word;
    logic                        accept;
    logic                        push;
    logic                        pop;

    logic [INSTRUCTON_WIDTH-1:0] mem_word_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]       mem_addr_q [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        illegal_q, illegal_d;

    // Map the opcode onto its encoding format; anything unlisted is illegal.
    always_comb begin
        fmt = FMT_BAD;
        unique case (bus.in_opcode)
            7'b0110011, 7'b0101111:                         fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b1101111:                                     fmt = FMT_J;
            7'b0010111, 7'b0110111:                         fmt = FMT_U;
            default:                                        fmt = FMT_BAD;
        endcase
    end

    assign legal = (fmt != FMT_BAD);

    // Pack the fields; immediate bits a format cannot carry simply fall away.
    always_comb begin
        word = '0;
        unique case (fmt)
            FMT_R: word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
            FMT_I: word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
            FMT_S: word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_imm[4:0], bus.in_opcode};
            FMT_B: word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                           bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            FMT_U: word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J: word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                           bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
            default: word = '0;
        endcase
    end

    // in_ready looks only at the registered count, so a full queue refuses input
    // even when the head is being popped on the same edge.
    assign bus.in_ready  = (count_q != FULL_CNT);
    assign bus.out_valid = (count_q != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && legal;
    assign pop           = bus.out_valid && bus.out_ready;

    // Next-state for pointers, occupancy, address counter and the sticky error.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        illegal_d = illegal_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            addr_d   = addr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (bus.in_clear_err) begin
            illegal_d = 1'b0;
        end
        if (accept && !legal) begin
            illegal_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
        end
    end

    // FIFO storage: each entry holds the encoded word and its address tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_word_q[i] <= '0;
                mem_addr_q[i] <= '0;
            end
        end else if (push) begin
            mem_word_q[wr_ptr_q] <= word;
            mem_addr_q[wr_ptr_q] <= addr_q;
        end
    end

    assign bus.out_instruction = bus.out_valid ? mem_word_q[rd_ptr_q] : '0;
    assign bus.out_addr        = bus.out_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.out_illegal     = illegal_q;
    assign bus.out_count       = count_q;
endmodule

// File: tb/tb_ie.sv
// tb/tb_ie.sv - randomized and directed self-checking bench for the instruction encoder
module tb_ie;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ie_if #(.ADDR_WIDTH(10), .FIFO_DEPTH(4)) ba ();
    ie_if #(.ADDR_WIDTH(2),  .FIFO_DEPTH(4)) bw ();

    assign bw.in_valid     = ba.in_valid;
    assign bw.in_opcode    = ba.in_opcode;
    assign bw.in_rd        = ba.in_rd;
    assign bw.in_rs1       = ba.in_rs1;
    assign bw.in_rs2       = ba.in_rs2;
    assign bw.in_funct3    = ba.in_funct3;
    assign bw.in_funct7    = ba.in_funct7;
    assign bw.in_imm       = ba.in_imm;
    assign bw.in_clear_err = ba.in_clear_err;
    assign bw.out_ready    = ba.out_ready;

    ie #(.INSTRUCTON_WIDTH(32), .FIFO_DEPTH(4), .ADDR_WIDTH(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ba)
    );

    ie #(.INSTRUCTON_WIDTH(32), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state: the queue as a list of (word, address) pairs.
    logic [31:0] q_word[$];
    int          q_addr[$];
    int          next_addr;
    bit          ill_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Encoding computed from the format tables with shifts and masks.
    function automatic bit model_enc(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm, output logic [31:0] w);
        int unsigned o, d, s1, s2, a3, a7, im;
        o = op; d = rd; s1 = rs1; s2 = rs2; a3 = f3; a7 = f7; im = imm;
        w = 32'h0;
        case (op)
            7'b0110011, 7'b0101111:
                w = (a7 << 25) | (s2 << 20) | (s1 << 15) | (a3 << 12) | (d << 7) | o;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                w = ((im & 32'hFFF) << 20) | (s1 << 15) | (a3 << 12) | (d << 7) | o;
            7'b0100011:
                w = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (a3 << 12)
                    | ((im & 32'h1F) << 7) | o;
            7'b1100011:
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
                    | (s1 << 15) | (a3 << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 1) << 7) | o;
            7'b0010111, 7'b0110111:
                w = (im & 32'hFFFFF000) | (d << 7) | o;
            7'b1101111:
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | o;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check("in_ready",   ba.in_ready,  q_word.size() < 4);
        check("out_valid",  ba.out_valid, q_word.size() > 0);
        check("out_count",  ba.out_count, q_word.size());
        check("out_instr",  ba.out_instruction, (q_word.size() > 0) ? q_word[0] : 32'h0);
        check("out_addr",   ba.out_addr,  (q_addr.size() > 0) ? q_addr[0] : 0);
        check("out_ill",    ba.out_illegal, ill_m);
        check("wrap_addr",  bw.out_addr,  (q_addr.size() > 0) ? (q_addr[0] % 4) : 0);
        check("wrap_count", bw.out_count, q_word.size());
    endtask

    task automatic model_reset();
        q_word.delete();
        q_addr.delete();
        next_addr = 0;
        ill_m     = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        ba.in_valid  = v;
        ba.in_opcode = op;
        ba.in_rd     = rd;
        ba.in_rs1    = rs1;
        ba.in_rs2    = rs2;
        ba.in_funct3 = f3;
        ba.in_funct7 = f7;
        ba.in_imm    = imm;
    endtask

    // One clock: predict from pre-edge model state, advance, then compare at negedge.
    task automatic tick(output bit accepted);
        bit          rdy, acc, pop, lg;
        logic [31:0] w;
        rdy = q_word.size() < 4;
        acc = ba.in_valid && rdy;
        pop = (q_word.size() > 0) && ba.out_ready;
        lg  = model_enc(ba.in_opcode, ba.in_rd, ba.in_rs1, ba.in_rs2, ba.in_funct3,
                        ba.in_funct7, ba.in_imm, w);
        @(posedge clk);
        if (pop) begin
            void'(q_word.pop_front());
            void'(q_addr.pop_front());
        end
        if (acc && lg) begin
            q_word.push_back(w);
            q_addr.push_back(next_addr);
            next_addr = (next_addr + 1) % 1024;
        end
        if (ba.in_clear_err) ill_m = 1'b0;
        if (acc && !lg) ill_m = 1'b1;
        accepted = acc;
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [6:0] legal_ops[10];

    initial begin
        bit acc;
        int n;
        // Unused fields carry junk that must not leak into the word.
        vecs[0] = '{7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'h0000_0005, 32'h0050_0093};
        vecs[1] = '{7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3};
        vecs[2] = '{7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h7F, 32'h0000_0008, 32'h0020_A423};
        vecs[3] = '{7'h63, 5'd31, 5'd1,  5'd2,  3'd0, 7'h7F, 32'h0000_0011, 32'h0020_8863};
        vecs[4] = '{7'h6F, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h0000_0800, 32'h0010_00EF};
        vecs[5] = '{7'h37, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5ABC, 32'h1234_52B7};
        legal_ops = '{7'h33, 7'h2F, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37};

        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        ba.out_ready    = 1'b1;
        ba.in_clear_err = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Every format, unused fields ignored.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].f3, vecs[i].f7, vecs[i].imm);
            tick(acc);
            check($sformatf("vec%0d_word", i), ba.out_instruction, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), ba.out_addr, i);
        end
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        tick(acc);

        // Backpressure: fill, hold the fifth until the queue drains.
        ba.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'h13, 5'(i), 5'd2, 5'd0, 3'd0, 7'h0, 32'(i + 1));
            n = 0;
            acc = 1'b0;
            while (!acc && n < 20) begin
                if (n == 3) ba.out_ready = 1'b1;
                tick(acc);
                n++;
            end
            check("bp_accept", acc, 1'b1);
            if (i == 3) check("full_count", ba.out_count, 4);
        end
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        ba.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(acc);

        // Illegal opcode between two legal ones, then clear and set-wins collision.
        drive(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1);
        tick(acc);
        drive(1'b1, 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1);
        tick(acc);
        check("ill_set", ba.out_illegal, 1'b1);
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h0, 32'h0);
        tick(acc);
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        ba.in_clear_err = 1'b1;
        tick(acc);
        check("ill_clr", ba.out_illegal, 1'b0);
        drive(1'b1, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        tick(acc);
        check("ill_setwins", ba.out_illegal, 1'b1);
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        tick(acc);
        ba.in_clear_err = 1'b0;
        tick(acc);

        // Reset mid-stream with three queued entries.
        ba.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'h0, 32'(i) << 12);
            tick(acc);
        end
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", ba.out_valid, 1'b0);
        check("rst_count", ba.out_count, 0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ba.out_ready = 1'b1;
        drive(1'b1, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 7'h0, 32'h7);
        tick(acc);
        check("post_rst_addr", ba.out_addr, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) < 2) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
            drive($urandom_range(0, 9) < 7, op, 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), $urandom);
            ba.out_ready    = $urandom_range(0, 1);
            ba.in_clear_err = ($urandom_range(0, 9) == 0);
            tick(acc);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ie.md
# ie

Instruction encoder: the inverse of the instruction decoder. It accepts decoded RISC-V fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) over a valid/ready handshake, packs them into a 32-bit instruction word according to the opcode's format, and buffers the words in a FIFO. Each word leaves tagged with a sequential instruction-memory address. It sits between the test-program generator or loader and the instruction memory write port.

## Interface

**Parameters**
- `INSTRUCTON_WIDTH`, 32: instruction word width. Only 32 is supported.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of two, ≥ 2.
- `ADDR_WIDTH`, 10: width of the word address counter.

**Ports** (clock and reset first)
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: the field set is valid.
- `in_ready`, output, 1: the block can accept; equals `!full`.
- `in_opcode`, input, 7: opcode.
- `in_rd`, `in_rs1`, `in_rs2`, input, 5 each: register indices.
- `in_funct3`, input, 3: funct3 field.
- `in_funct7`, input, 7: funct7 field.
- `in_imm`, input, 32: unpacked immediate, in the same bit positions the decoder produces.
- `in_clear_err`, input, 1: clears `out_illegal`.
- `out_valid`, output, 1: the FIFO is not empty.
- `out_ready`, input, 1: the consumer takes the head entry.
- `out_instruction`, output, 32: head entry's encoded word.
- `out_addr`, output, ADDR_WIDTH: head entry's word address.
- `out_illegal`, output, 1: sticky flag; an unknown opcode was dropped.
- `out_count`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

**Handshakes**
- Accept occurs when `in_valid && in_ready` at a rising edge.
- Pop occurs when `out_valid && out_ready` at a rising edge.

**Opcode to format mapping**
- R: 0110011, 0101111
- I: 0010011, 0000011, 1100111, 1110011
- S: 0100011
- B: 1100011
- J: 1101111
- U: 0010111, 0110111

**Packing** (MSB to LSB)
- R: funct7 | rs2 | rs1 | funct3 | rd | opcode
- I: imm[11:0] | rs1 | funct3 | rd | opcode
- S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
- B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
- U: imm[31:12] | rd | opcode
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode

**Field and address rules**
- Fields a format does not use are ignored.
- Immediate bits the format cannot encode are silently discarded: imm[0] for B and J, imm[11:0] for U, imm[31:12] for I and S.
- The address counter starts at 0 and increments by 1 per legal accepted instruction. It wraps from 2^ADDR_WIDTH−1 to 0 with no flag.

**Unknown opcodes**
- The instruction is accepted (handshake completes) but nothing is written to the FIFO.
- The address counter does not advance.
- `out_illegal` is set on the same edge.

**`out_illegal` set/clear**
- `in_clear_err` clears the flag.
- If clear and a new illegal accept occur on the same edge, set wins.

**FIFO**
- Circular buffer with read and write pointers plus an occupancy count.
- Stores {word, addr} per entry.
- `in_ready` depends only on the registered count. It is not combinationally dependent on `out_ready`, so a full FIFO rejects input even if a pop occurs on the same edge.
- Simultaneous push and pop when non-full and non-empty: count is unchanged and both pointers advance.

## Timing

**Reset** (`rst_n` low, immediate and asynchronous)
- Count = 0, pointers = 0, address counter = 0.
- `out_valid` = 0, `in_ready` = 1, `out_illegal` = 0, `out_count` = 0.
- `out_instruction` and `out_addr` = 0.
- Reset asserted mid-stream discards all FIFO contents. No partial entry survives.

**Latency**
- A word accepted at edge N appears on `out_instruction` with `out_valid` = 1 after edge N, provided the FIFO was empty.
- Latency is one cycle; there is no combinational input-to-output path.
- Throughput is one instruction per cycle while not full.

**Output stability**
- `out_instruction` and `out_addr` are registered-buffer reads.
- They remain stable while `out_valid && !out_ready`.
- When the FIFO is empty, they read 0.

## Test plan

- **Encoding of every format.** Apply these sequentially with `out_ready` = 1.
  - addi x1,x0,5 (0010011, rd=1, f3=0, imm=5) → 0x00500093, addr 0.
  - add x3,x1,x2 → 0x002081B3, addr 1.
  - sw x2,8(x1) → 0x0020A423.
  - beq x1,x2,+16 → 0x00208863.
  - jal x1,+0x800 → 0x001000EF.
  - lui x5,imm=0x12345000 → 0x123452B7.
- **Backpressure and full.** Hold `out_ready` = 0 and push 5 instructions.
  - `in_ready` drops after the 4th accept; `out_count` = 4.
  - The 5th instruction is held until the first pop.
  - Order and addresses 0–4 are preserved.
- **Illegal opcode.** Push 0x7F between two legal instructions.
  - The legal instructions get addr 0 and 1; the illegal one produces no entry.
  - `out_illegal` rises one edge after the illegal accept.
  - `in_clear_err` clears it; set wins on a same-edge collision.
- **Address wrap.** With ADDR_WIDTH = 2, push 5 legal instructions → addresses 0, 1, 2, 3, 0.
- **Reset mid-stream.** With 3 entries queued, pulse `rst_n` low asynchronously between edges.
  - `out_valid` = 0 and `out_count` = 0 immediately.
  - The next accepted instruction gets addr 0.
